// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkg
// Description : Shared constants, FSM state type and T-word expansion for the
//               Smith-Waterman sequence-storage controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int Score_Width     = 10;
    localparam int Pe_Chars        = 7;
    localparam int Pe_Field        = 2 + 2 * Score_Width;
    localparam int Sram_Word       = 4 + Pe_Chars * Pe_Field;
    localparam int Sram_Addr       = 1024;
    localparam int Sram_Addr_Width = $clog2(Sram_Addr);
    localparam int Max_T_size_log  = $clog2(Sram_Addr) + 1;

    // Header bit positions in the incoming T word and in the stored packet
    localparam int T_Valid_Bit   = 17;
    localparam int T_Last_Bit    = 16;
    localparam int Pkt_Valid_Bit = Sram_Word - 1;
    localparam int Pkt_Last_Bit  = Sram_Word - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_LOAD      = 2'd2
    } sw_state_t;

    // Expand one T word into a PE packet: 4 header bits, then seven
    // {char, V, F} fields with char0 most significant and scores zeroed.
    function automatic logic [Sram_Word-1:0] expand_t(input logic [17:0] t);
        logic [Sram_Word-1:0] p;
        p = '0;
        p[Sram_Word-1 -: 4] = t[17:14];
        for (int k = 0; k < Pe_Chars; k++) begin
            p[Sram_Word-5-k*Pe_Field -: 2] = t[13-2*k -: 2];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank
// Description : Sram_Addr x Sram_Word memory, one write port and one
//               registered read port with read-before-write behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank
    import sw_pkg::*;
(
    input  logic                       clk,
    input  logic                       we,
    input  logic [Sram_Addr_Width-1:0] waddr,
    input  logic [Sram_Word-1:0]       wdata,
    input  logic                       rd_en,
    input  logic [Sram_Addr_Width-1:0] raddr,
    output logic [Sram_Word-1:0]       rdata
);

    logic [Sram_Word-1:0] r_mem [Sram_Addr];
    logic [Sram_Word-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; returns contents prior to a same-edge write
    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Loads the T sequence into the packet memory, then serves
//               packets to the PE chain and accepts write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sw_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start_read_t,
    input  logic [17:0]               i_t,
    input  logic                      i_init,
    input  logic                      i_PE_request,
    output logic [Sram_Word-1:0]      o_request_data,
    input  logic                      i_PE_send,
    input  logic [Sram_Word-1:0]      i_send_data,
    output logic                      o_busy,
    output logic [Max_T_size_log-1:0] o_T_size
);

    sw_state_t                  r_state;
    logic [Sram_Addr_Width-1:0] r_load_ptr;
    logic [Sram_Addr_Width-1:0] r_rd_ptr;
    logic [Sram_Addr_Width-1:0] r_wr_ptr;
    logic [Max_T_size_log-1:0]  r_T_size;
    logic                       r_busy;
    logic                       r_rd_valid;

    logic                       w_idle;
    logic                       w_load;
    logic                       w_rd_fire;
    logic                       w_wr_fire;
    logic                       w_bank_we;
    logic [Sram_Addr_Width-1:0] w_bank_waddr;
    logic [Sram_Word-1:0]       w_bank_wdata;
    logic [Sram_Word-1:0]       w_bank_rdata;
    logic [Max_T_size_log-1:0]  w_last_idx;
    logic [Sram_Addr_Width-1:0] w_rd_ptr_nxt;
    logic [Sram_Addr_Width-1:0] w_wr_ptr_nxt;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_load    = (r_state == ST_LOAD);
    assign w_rd_fire = w_idle && i_PE_request && (r_T_size != '0);
    assign w_wr_fire = w_idle && i_PE_send;

    // Loading owns the write port; PE write-backs only reach it in IDLE
    assign w_bank_we    = w_load || w_wr_fire;
    assign w_bank_waddr = w_load ? r_load_ptr : r_wr_ptr;
    assign w_bank_wdata = w_load ? expand_t(i_t) : i_send_data;

    // Both service pointers wrap after the last loaded packet
    assign w_last_idx   = r_T_size - Max_T_size_log'(1);
    assign w_rd_ptr_nxt = ({1'b0, r_rd_ptr} == w_last_idx) ? '0 : r_rd_ptr + Sram_Addr_Width'(1);
    assign w_wr_ptr_nxt = ({1'b0, r_wr_ptr} == w_last_idx) ? '0 : r_wr_ptr + Sram_Addr_Width'(1);

    sram_bank u_bank (
        .clk   (clk),
        .we    (w_bank_we),
        .waddr (w_bank_waddr),
        .wdata (w_bank_wdata),
        .rd_en (w_rd_fire),
        .raddr (r_rd_ptr),
        .rdata (w_bank_rdata)
    );

    // Control FSM, pointers, packet count and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_load_ptr <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_T_size   <= '0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            case (r_state)
                ST_IDLE: begin
                    if (i_start_read_t) begin
                        r_state    <= ST_LOAD_WAIT;
                        r_busy     <= 1'b1;
                        r_load_ptr <= '0;
                        r_rd_ptr   <= '0;
                        r_wr_ptr   <= '0;
                        r_T_size   <= '0;
                    end else if (i_init) begin
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                    end else begin
                        if (w_rd_fire) begin
                            r_rd_ptr <= w_rd_ptr_nxt;
                        end
                        if (w_wr_fire) begin
                            r_wr_ptr <= w_wr_ptr_nxt;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_load_ptr <= r_load_ptr + Sram_Addr_Width'(1);
                    r_T_size   <= r_T_size + Max_T_size_log'(1);
                    // Stop on the last-word flag or when the memory is full
                    if (i_t[T_Last_Bit] || (r_load_ptr == Sram_Addr_Width'(Sram_Addr - 1))) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_request_data = r_rd_valid ? w_bank_rdata : '0;
    assign o_busy         = r_busy;
    assign o_T_size       = r_T_size;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller: table of load
//               scenarios plus wrap, write-back and reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;
    import sw_pkg::*;

    localparam int W = Sram_Word;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      i_start_read_t = 1'b0;
    logic [17:0]               i_t = '0;
    logic                      i_init = 1'b0;
    logic                      i_PE_request = 1'b0;
    logic [W-1:0]              o_request_data;
    logic                      i_PE_send = 1'b0;
    logic [W-1:0]              i_send_data = '0;
    logic                      o_busy;
    logic [Max_T_size_log-1:0] o_T_size;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_mem [Sram_Addr];
    int           model_rd, model_wr, model_size;
    logic [W-1:0] sb [$];

    typedef struct {
        int         n_words;
        int         last_idx;
        int         seed;
        logic [1:0] rsv;
        int         exp_size;
        int         exp_busy;
    } load_vec_t;

    load_vec_t vecs [4];

    sram_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start_read_t (i_start_read_t),
        .i_t            (i_t),
        .i_init         (i_init),
        .i_PE_request   (i_PE_request),
        .o_request_data (o_request_data),
        .i_PE_send      (i_PE_send),
        .i_send_data    (i_send_data),
        .o_busy         (o_busy),
        .o_T_size       (o_T_size)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent packet model written as an explicit concatenation
    function automatic logic [W-1:0] model_pkt(input logic [17:0] t);
        return {t[17:14],
                t[13:12], 20'h0, t[11:10], 20'h0, t[9:8], 20'h0, t[7:6], 20'h0,
                t[5:4],   20'h0, t[3:2],   20'h0, t[1:0], 20'h0};
    endfunction

    function automatic logic [17:0] word_of(input load_vec_t v, input int k);
        logic [17:0] w;
        w = 18'h20000 | {2'b00, v.rsv, 14'h0};
        if (k == v.last_idx) w = w | 18'h10000;
        else                 w = w | {4'h0, 14'(k * v.seed)};
        return w;
    endfunction

    function automatic int wrap_next(input int p);
        if (model_size > 0 && p == model_size - 1) return 0;
        return (p + 1) % Sram_Addr;
    endfunction

    // One cycle of PE traffic: compare the previous read, drive this one,
    // push its expected result and update the memory model.
    task automatic step(input bit req, input bit snd, input logic [W-1:0] d, input bit ini);
        logic [W-1:0] e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("read_data", o_request_data, e);
        end
        i_PE_request = req;
        i_PE_send    = snd;
        i_send_data  = d;
        i_init       = ini;
        e = (req && model_size > 0) ? model_mem[model_rd] : '0;
        sb.push_back(e);
        if (ini) begin
            model_rd = 0;
            model_wr = 0;
        end else begin
            if (req && model_size > 0) model_rd = wrap_next(model_rd);
            if (snd) begin
                model_mem[model_wr] = d;
                model_wr = wrap_next(model_wr);
            end
        end
    endtask

    task automatic flush();
        logic [W-1:0] e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("read_data", o_request_data, e);
        end
        i_PE_request = 1'b0;
        i_PE_send    = 1'b0;
        i_init       = 1'b0;
        i_send_data  = '0;
    endtask

    // Load a stream while hammering request/send, which must be ignored
    task automatic run_load(input load_vec_t v);
        int busy_cycles;
        int nonzero;
        busy_cycles = 0;
        nonzero     = 0;
        model_size  = 0;
        for (int k = 0; k < v.n_words; k++) begin
            model_mem[k] = model_pkt(word_of(v, k));
            model_size++;
            if (k == v.last_idx || model_size == Sram_Addr) break;
        end
        model_rd = 0;
        model_wr = 0;
        @(negedge clk);
        i_start_read_t = 1'b1;
        @(negedge clk);
        i_start_read_t = 1'b0;
        i_PE_request   = 1'b1;
        i_PE_send      = 1'b1;
        i_send_data    = '1;
        for (int c = 0; c < v.n_words + 10; c++) begin
            if (o_request_data !== '0) nonzero++;
            if (!o_busy) break;
            busy_cycles++;
            if (c == 0)                         i_t = 18'h2AAAA;
            else if (c - 1 < v.n_words)         i_t = word_of(v, c - 1);
            else                                i_t = 18'h0;
            @(negedge clk);
        end
        i_PE_request = 1'b0;
        i_PE_send    = 1'b0;
        i_send_data  = '0;
        i_t          = '0;
        chk("busy_cycles", W'(busy_cycles), W'(v.exp_busy));
        chk("busy_read_zero", W'(nonzero), W'(0));
        chk("t_size", W'(o_T_size), W'(v.exp_size));
    endtask

    initial begin
        //            n     last seed rsv  size  busy
        vecs[0] = '{  5,     4,   1, 2'b00,    5,    6};
        vecs[1] = '{  3,     2,   5, 2'b11,    3,    4};
        vecs[2] = '{  1,     0,   3, 2'b01,    1,    2};
        vecs[3] = '{1028,   -1,   7, 2'b10, 1024, 1025};

        // Reset behaviour
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_data", o_request_data, '0);
        chk("rst_size", W'(o_T_size), W'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", W'(o_busy), W'(0));

        // Requests with nothing loaded return zero
        model_size = 0; model_rd = 0; model_wr = 0;
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        flush();

        // Table of load scenarios, each followed by a full read plus one wrap
        for (int i = 0; i < 4; i++) begin
            run_load(vecs[i]);
            for (int r = 0; r <= vecs[i].exp_size; r++) step(1, 0, '0, 0);
            flush();
            step(0, 0, '0, 0);
            flush();
        end

        // Wrap: 3 packets, 7 consecutive requests
        run_load('{3, 2, 9, 2'b10, 3, 4});
        for (int r = 0; r < 7; r++) step(1, 0, '0, 0);
        flush();

        // Write-back: send 3 all-ones, rewind, read them back
        step(0, 0, '0, 1);
        for (int r = 0; r < 3; r++) step(0, 1, '1, 0);
        step(0, 0, '0, 1);
        for (int r = 0; r < 3; r++) step(1, 0, '0, 0);
        flush();

        // Same-cycle send and request to one address returns the old value
        step(0, 0, '0, 1);
        step(1, 1, {W/2{2'b10}}, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 1);
        step(1, 0, '0, 0);
        flush();

        // Reset in the middle of a load aborts it
        @(negedge clk);
        i_start_read_t = 1'b1;
        @(negedge clk);
        i_start_read_t = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_t = 18'h20000 | 18'(c);
            @(negedge clk);
        end
        chk("midload_busy", W'(o_busy), W'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midload_rst_busy", W'(o_busy), W'(0));
        chk("midload_rst_size", W'(o_T_size), W'(0));
        rst_n = 1'b1;
        i_t   = '0;
        model_size = 0; model_rd = 0; model_wr = 0;
        step(1, 0, '0, 0);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Sequence-storage controller for the Smith-Waterman array. It loads the target sequence T from an external 18-bit stream into an on-chip word memory. Each T word is expanded into a PE packet with zeroed score fields. The block then serves packets to the PE chain on request and accepts updated packets written back by the PE chain.

## Interface
Parameters (shared package constants):
- Sram_Word, 158: packet width = 4 + 7·(2 + 2·Score_Width).
- Score_Width, 10: width of each per-character score field (V and F).
- Sram_Addr, 1024: memory depth in packets.
- Max_T_size_log, 11: width of o_T_size, equal to clog2(Sram_Addr)+1.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- i_start_read_t, in, 1: one-cycle pulse that starts loading T.
- i_t, in, 18: T stream word. Bit 17 = valid, bit 16 = last, bits 15:14 reserved, bits 13:0 = seven 2-bit characters (char0 in 13:12).
- i_init, in, 1: rewinds the read and write pointers to 0.
- i_PE_request, in, 1: PE requests the next packet.
- o_request_data, out, Sram_Word: packet output; bit Sram_Word-1 = valid.
- i_PE_send, in, 1: PE writes a packet back.
- i_send_data, in, Sram_Word: write-back packet.
- o_busy, out, 1: high while loading T.
- o_T_size, out, Max_T_size_log: number of packets loaded.

## Operation
- States: IDLE, LOAD_WAIT, LOAD.
- IDLE → LOAD_WAIT: on i_start_read_t. The transition clears the load pointer, rd_ptr, wr_ptr and o_T_size.
- LOAD_WAIT → LOAD: after one cycle; i_t is ignored in this cycle.
- LOAD: each rising edge samples i_t and stores packet = {i_t[17:14], then for k=0..6: i_t[13-2k:12-2k], V=0, F=0}. V and F are each Score_Width bits, with char0 most significant. The load pointer and o_T_size increment.
- LOAD → IDLE: after storing a word with bit 16 = 1, or after storing word Sram_Addr-1 (overflow truncation).
- o_busy = 1 in LOAD_WAIT and LOAD.
- Request (IDLE only, o_T_size > 0): on an edge with i_PE_request=1, o_request_data ← mem[rd_ptr] and rd_ptr increments. rd_ptr wraps to 0 after o_T_size-1.
- When there is no request, o_T_size = 0, or the state is not IDLE, o_request_data ← 0.
- Send (IDLE only): on an edge with i_PE_send=1, mem[wr_ptr] ← i_send_data; wr_ptr increments with the same wrap rule. Sends outside IDLE are dropped.
- i_init in IDLE sets rd_ptr = wr_ptr = 0; memory and o_T_size are kept. i_init is ignored while busy.
- Request and send to the same address in one cycle: the read returns the old contents.
- i_start_read_t while busy is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - o_busy = 0, o_request_data = 0, o_T_size = 0.
  - All pointers = 0.
  - Memory contents are undefined.
- o_busy rises one cycle after the i_start_read_t edge.
- Stream word n is sampled at the (n+2)th edge after that start edge.
- o_busy falls the cycle after the last word is stored.
- Read latency: 1 cycle, registered output, one packet per cycle under continuous request.
- Write latency: 1 cycle. Data is readable from the next cycle.
- Reset mid-load aborts to IDLE with o_T_size = 0.

## Structure
- Package sw_pkg holds Sram_Word, Score_Width, Sram_Addr, Max_T_size_log, the header bit indices, and the t-to-packet expansion function.
- Sub-module sram_bank: Sram_Addr × Sram_Word memory with one write port and one registered read port (read-before-write).
- The controller FSM and pointers live in sram_controller.

## Test plan
- Reset: during reset all outputs are 0. After reset, o_busy stays 0.
- Load 5 words then read:
  - Stimulus: pulse start; feed 0x20000|k for k=0..3, then 0x30000 with last set.
  - o_busy is high for 6 cycles, then falls; o_T_size = 5.
  - Holding i_PE_request gives packets whose MSB is 1 and whose header equals i_t[17:14], chars match, and all V/F = 0.
- Wrap: with 3 words loaded, 7 consecutive requests return packets 0,1,2,0,1,2,0.
- Write-back:
  - Send 3 packets of all-ones.
  - Pulse i_init, then request 3: all-ones returned.
  - Send and request on the same cycle returns the old value.
- Overflow: stream Sram_Addr+4 words with no last bit → the load stops after Sram_Addr words and o_T_size = Sram_Addr.
- Busy guard:
  - While loading, i_PE_request=1 gives o_request_data = 0.
  - i_PE_send during the load does not corrupt the loaded packets.
